// File: rtl/charbuf_term.sv
// charbuf_term: terminal character buffer with cursor, wrap, hardware scroll and a 2-cycle video read port
// Ports: clk/reset (async, active high); in_valid/in_ready/in_data byte stream from the UART receiver;
//   rd_en/rd_col/rd_row -> rd_data/rd_valid two cycles later; cur_col/cur_row cursor position;
//   top_row physical row shown as screen row 0; busy while the buffer is being blanked.
// Build option: define CHARBUF_TERM_TAB_EN to make 0x09 advance the cursor to the next multiple of 8.
module charbuf_term #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         DATA_W = 8,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rd_en,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(ROWS)-1:0]  top_row,
  output logic                     busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     clr_row_q, clr_row_d;
  logic [CW-1:0]     cur_col_q, cur_col_d;
  logic [RW-1:0]     cur_row_q, cur_row_d;
  logic [RW-1:0]     top_row_q, top_row_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              rd_v1_q, rd_v1_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem [N];
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              acc, nl, col_last;
  logic              is_pr, is_cr, is_lf, is_bs, tab_nl;
  logic [CW-1:0]     tab_col;
  logic [7:0]        c;
  // logical row -> physical row via add and conditional subtract
  function automatic logic [RW-1:0] phys(input logic [RW-1:0] lr, input logic [RW-1:0] top);
    logic [RW:0] s;
    s = {1'b0, lr} + {1'b0, top};
    return s >= (RW+1)'(ROWS) ? RW'(s - (RW+1)'(ROWS)) : RW'(s);
  endfunction
  function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
    return AW'(r) * AW'(COLS);
  endfunction
  assign c        = in_data[7:0];
  assign is_pr    = c >= 8'h20 && c <= 8'h7E;
  assign is_cr    = c == 8'h0D;
  assign is_lf    = c == 8'h0A;
  assign is_bs    = c == 8'h08;
  assign col_last = cur_col_q == CW'(COLS - 1);
  assign acc      = in_ready && in_valid;
`ifdef CHARBUF_TERM_TAB_EN
  // widened so the next tab stop never wraps inside the adder for small COLS
  localparam int TW = (CW > 3 ? CW : 3) + 1;
  logic          is_tab, tab_wrap;
  logic [TW-1:0] tab_n;
  assign is_tab   = c == 8'h09;
  assign tab_n    = (TW'(cur_col_q) | TW'(7)) + TW'(1);
  assign tab_wrap = tab_n >= TW'(COLS);
  assign tab_col  = is_tab ? (tab_wrap ? '0 : CW'(tab_n)) : cur_col_q;
  assign tab_nl   = is_tab && tab_wrap;
`else
  assign tab_col  = cur_col_q;
  assign tab_nl   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      clr_row_q  <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      top_row_q  <= '0;
      rd_addr_q  <= '0;
      rd_v1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_row_q  <= clr_row_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      top_row_q  <= top_row_d;
      rd_addr_q  <= rd_addr_d;
      rd_v1_q    <= rd_v1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  // storage is not reset; a read of the cell written on the same edge sees the old value
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_row_d = clr_row_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    top_row_d = top_row_q;
    nl        = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        cur_col_d = is_pr ? (col_last ? '0 : cur_col_q + CW'(1))
                  : is_cr ? '0
                  : is_bs ? (cur_col_q != '0 ? cur_col_q - CW'(1) : cur_col_q)
                  : tab_col;
        nl = (is_pr && col_last) || is_lf || tab_nl;
        if (nl && cur_row_q != RW'(ROWS - 1))
          cur_row_d = cur_row_q + RW'(1);
        else if (nl) begin
          // scroll: the old top row becomes the new bottom row and is blanked
          top_row_d = top_row_q == RW'(ROWS - 1) ? '0 : top_row_q + RW'(1);
          clr_row_d = top_row_q;
          cnt_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = cnt_q == AW'(COLS - 1) ? '0 : cnt_q + AW'(1);
        state_d = cnt_q == AW'(COLS - 1) ? IDLE : CLEAR;
      end
      default: begin
        cnt_d   = cnt_q == AW'(N - 1) ? '0 : cnt_q + AW'(1);
        state_d = cnt_q == AW'(N - 1) ? IDLE : INIT;
      end
    endcase
    rd_addr_d  = row_base(phys(rd_row, top_row_q)) + AW'(rd_col);
    rd_v1_d    = rd_en;
    rd_valid_d = rd_v1_q;
    rd_data_d  = rd_v1_q ? mem[rd_addr_q] : rd_data_q;
  end
  always_comb begin
    in_ready = state_q == IDLE;
    busy     = state_q != IDLE;
    we       = state_q == IDLE ? acc && is_pr : 1'b1;
    wd       = state_q == IDLE ? in_data : DATA_W'(BLANK);
    wa       = state_q == IDLE  ? row_base(phys(cur_row_q, top_row_q)) + AW'(cur_col_q)
             : state_q == CLEAR ? row_base(clr_row_q) + cnt_q
             : cnt_q;
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign cur_col  = cur_col_q;
  assign cur_row  = cur_row_q;
  assign top_row  = top_row_q;
endmodule

// File: tb/tb_charbuf_term.sv
// tb_charbuf_term: scoreboard bench for charbuf_term at COLS=8, ROWS=4
module tb_charbuf_term;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int DATA_W = 8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_col = '0;
  logic [1:0] rd_row = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] cur_col;
  logic [1:0] cur_row;
  logic [1:0] top_row;
  logic       busy;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  charbuf_term #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
    .cur_col(cur_col), .cur_row(cur_row), .top_row(top_row), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask
  task automatic send(input logic [7:0] ch);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_ready got=0 exp=1");
    end
    in_valid = 1'b1;
    in_data  = ch;
    step();
    in_valid = 1'b0;
  endtask
  task automatic rd(input logic [1:0] r, input logic [2:0] cl, input logic [7:0] e);
    rd_en  = 1'b1;
    rd_row = r;
    rd_col = cl;
    exp_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check("rd_drain", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_top", 32'(top_row), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    wait_ready("init_cycles", COLS * ROWS);
    check("init_busy", 32'(busy), 32'd0);
  endtask
  always @(negedge clk)
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_extra", 32'(rd_valid), 32'd0);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int cl = 0; cl < COLS; cl++) rd(2'(r), 3'(cl), 8'h20);
    drain();
    send(8'h41);
    send(8'h42);
    check("ab_col", 32'(cur_col), 32'd2);
    rd(2'd0, 3'd0, 8'h41);
    check("rd_lat1", 32'(rd_valid), 32'd0);
    step();
    check("rd_lat2", 32'(rd_valid), 32'd1);
    rd(2'd0, 3'd1, 8'h42);
    drain();
    send(8'h0D);
    for (int i = 0; i < 9; i++) send(8'(8'h30 + i));
    check("wrap_row", 32'(cur_row), 32'd1);
    check("wrap_col", 32'(cur_col), 32'd1);
    for (int cl = 0; cl < COLS; cl++) rd(2'd0, 3'(cl), 8'(8'h30 + cl));
    rd(2'd1, 3'd0, 8'h38);
    rd(2'd1, 3'd1, 8'h20);
    drain();
    do_reset();
    repeat (3) send(8'h0A);
    check("lf_row", 32'(cur_row), 32'd3);
    check("lf_top", 32'(top_row), 32'd0);
    send(8'h5A);
    send(8'h0A);
    check("clear_busy", 32'(busy), 32'd1);
    wait_ready("clear_cycles", COLS);
    check("scroll_top", 32'(top_row), 32'd1);
    check("scroll_row", 32'(cur_row), 32'd3);
    check("scroll_col", 32'(cur_col), 32'd1);
    for (int cl = 0; cl < COLS; cl++) rd(2'd3, 3'(cl), 8'h20);
    rd(2'd2, 3'd0, 8'h5A);
    rd(2'd2, 3'd1, 8'h20);
    drain();
    send(8'h0D);
    check("cr_col", 32'(cur_col), 32'd0);
    send(8'h08);
    check("bs_at0", 32'(cur_col), 32'd0);
    send(8'h7F);
    send(8'h1F);
    check("ctrl_ignored", 32'(cur_col), 32'd0);
    send(8'h7E);
    send(8'h62);
    send(8'h63);
    check("print_col", 32'(cur_col), 32'd3);
    send(8'h08);
    check("bs_col", 32'(cur_col), 32'd2);
    send(8'h0D);
    check("bs_cr_col", 32'(cur_col), 32'd0);
    check("bs_row", 32'(cur_row), 32'd3);
    check("bs_top", 32'(top_row), 32'd1);
    rd(2'd3, 3'd0, 8'h7E);
    rd(2'd3, 3'd1, 8'h62);
    rd(2'd3, 3'd2, 8'h63);
    rd(2'd3, 3'd3, 8'h20);
    drain();
    send(8'h71);
    send(8'h72);
    send(8'h73);
    send(8'h09);
`ifdef CHARBUF_TERM_TAB_EN
    wait_ready("tab_clear", COLS);
    check("tab_col", 32'(cur_col), 32'd0);
    check("tab_top", 32'(top_row), 32'd2);
    check("tab_row", 32'(cur_row), 32'd3);
`else
    check("tab_col", 32'(cur_col), 32'd3);
    check("tab_top", 32'(top_row), 32'd1);
    rd(2'd3, 3'd3, 8'h20);
    rd(2'd3, 3'd2, 8'h73);
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
